// File: rtl/sprite_pkg.sv
// Shared constants, types and the per-frame base helper for the sprite frame-RAM read path.
package sprite_pkg;

  localparam int DEF_SPR_W = 20;
  localparam int DEF_SPR_H = 20;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int RAM_AW    = 19;
  localparam int PIX_W     = 5;

  typedef logic [PIX_W-1:0] pix_idx_t;
  typedef logic [9:0]       coord_t;

  // Evaluated only at elaboration to build the per-frame base lookup table.
  function automatic logic [RAM_AW-1:0] frame_base(input int f,
                                                   input int spr_w = DEF_SPR_W,
                                                   input int spr_h = DEF_SPR_H);
    int prod;
    prod = f * spr_w * spr_h;
    return RAM_AW'(prod);
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation frame sequencer and once-per-frame position latch for one sprite.
// With SPRITE_MIRROR_EN defined, a mirror input is latched alongside the position.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 3,
  parameter int ANIM_DIV   = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       anim_en,
  input  logic       frame_rst,
  input  coord_t     pos_x,
  input  coord_t     pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic       mirror,
`endif
  output coord_t     px_l,
  output coord_t     py_l,
  output logic       mirror_l,
  output logic [1:0] cur_frame
);

  localparam int              DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0]      FRAME_LAST = 2'(NUM_FRAMES - 1);

  logic [DIV_W-1:0] r_div, w_div_next;
  logic [1:0]       r_frame, w_frame_next;
  coord_t           r_px, r_py;
  logic             r_mirror;
  logic             w_mirror_in;

`ifdef SPRITE_MIRROR_EN
  assign w_mirror_in = mirror;
`else
  assign w_mirror_in = 1'b0;
`endif

  // frame_rst wins over a coincident advance and also clears the divider.
  always_comb begin
    w_div_next   = r_div;
    w_frame_next = r_frame;
    if (frame_rst) begin
      w_div_next   = '0;
      w_frame_next = '0;
    end else if (frame_tick && anim_en) begin
      if (r_div == DIV_LAST) begin
        w_div_next   = '0;
        w_frame_next = (r_frame == FRAME_LAST) ? 2'd0 : r_frame + 2'd1;
      end else begin
        w_div_next = r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div    <= '0;
      r_frame  <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_mirror <= 1'b0;
    end else begin
      r_div   <= w_div_next;
      r_frame <= w_frame_next;
      if (frame_tick) begin
        r_px     <= pos_x;
        r_py     <= pos_y;
        r_mirror <= w_mirror_in;
      end
    end
  end

  assign px_l      = r_px;
  assign py_l      = r_py;
  assign mirror_l  = r_mirror;
  assign cur_frame = r_frame;

endmodule

// File: rtl/sprite_fetch.sv
// Sprite frame-RAM read engine: address generation, 3-cycle aligned palette index and pixel_on.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W           = DEF_SPR_W,
  parameter int SPR_H           = DEF_SPR_H,
  parameter int NUM_FRAMES      = 3,
  parameter int ANIM_DIV        = 8,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              frame_tick,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  input  logic              anim_en,
  input  logic              frame_rst,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [RAM_AW-1:0] read_address,
  input  pix_idx_t          ram_data,
  output pix_idx_t          pixel_idx,
  output logic              pixel_on,
  output logic [1:0]        cur_frame
);

  coord_t            w_px_l, w_py_l;
  logic              w_mirror_l;
  logic [1:0]        w_frame;
  logic [RAM_AW-1:0] w_base_lut [4];
  logic [RAM_AW-1:0] w_base, w_offset, w_addr_next;
  logic [10:0]       w_dx, w_dy, w_col;
  logic              w_hit, w_opaque;

  logic [RAM_AW-1:0] r_read_address;
  logic              r_hit_d1, r_hit_d2, r_pixel_on;
  pix_idx_t          r_pixel_idx;

  sprite_anim_ctr #(
    .NUM_FRAMES (NUM_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .frame_rst  (frame_rst),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .px_l       (w_px_l),
    .py_l       (w_py_l),
    .mirror_l   (w_mirror_l),
    .cur_frame  (w_frame)
  );

  // Constant base per frame index; unused slots point at 0 so any index stays in range.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_base
      if (gi < NUM_FRAMES) begin : g_used
        assign w_base_lut[gi] = frame_base(gi, SPR_W, SPR_H);
      end else begin : g_unused
        assign w_base_lut[gi] = '0;
      end
    end
  endgenerate

  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
  assign w_dx   = {1'b0, DrawX} - {1'b0, w_px_l};
  assign w_dy   = {1'b0, DrawY} - {1'b0, w_py_l};
  assign w_hit  = !w_dx[10] && (w_dx < 11'(SPR_W)) && !w_dy[10] && (w_dy < 11'(SPR_H));
  assign w_col  = w_mirror_l ? (11'(SPR_W - 1) - w_dx) : w_dx;
  assign w_base = w_base_lut[w_frame];
  assign w_offset    = RAM_AW'(w_dy) * RAM_AW'(SPR_W) + RAM_AW'(w_col);
  assign w_addr_next = w_hit ? (w_base + w_offset) : w_base;
  assign w_opaque    = r_hit_d2 && (ram_data != PIX_W'(TRANSPARENT_IDX));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_read_address <= '0;
      r_hit_d1       <= 1'b0;
      r_hit_d2       <= 1'b0;
      r_pixel_on     <= 1'b0;
      r_pixel_idx    <= '0;
    end else begin
      r_read_address <= w_addr_next;
      r_hit_d1       <= w_hit;
      r_hit_d2       <= r_hit_d1;
      r_pixel_on     <= w_opaque;
      r_pixel_idx    <= w_opaque ? ram_data : '0;
    end
  end

  assign read_address = r_read_address;
  assign pixel_on     = r_pixel_on;
  assign pixel_idx    = r_pixel_idx;
  assign cur_frame    = w_frame;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a behavioural 1-cycle-latency frame RAM.
module tb_sprite_fetch;
  import sprite_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  coord_t            DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic              frame_tick = 1'b0, anim_en = 1'b0, frame_rst = 1'b0;
`ifdef SPRITE_MIRROR_EN
  logic              mirror = 1'b0;
`endif
  logic [RAM_AW-1:0] read_address;
  pix_idx_t          ram_data, pixel_idx;
  logic              pixel_on;
  logic [1:0]        cur_frame;

  logic [4:0] mem [0:2047];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    coord_t x;
    coord_t y;
    int     addr;
    int     on;
    int     idx;
  } vec_t;

  vec_t vecs [9];

  sprite_fetch dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .frame_tick   (frame_tick),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .anim_en      (anim_en),
    .frame_rst    (frame_rst),
`ifdef SPRITE_MIRROR_EN
    .mirror       (mirror),
`endif
    .read_address (read_address),
    .ram_data     (ram_data),
    .pixel_idx    (pixel_idx),
    .pixel_on     (pixel_on),
    .cur_frame    (cur_frame)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) ram_data <= mem[read_address[10:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input coord_t px, input coord_t py, input logic rst);
    @(negedge Clk);
    pos_x = px; pos_y = py; frame_tick = 1'b1; frame_rst = rst;
    @(negedge Clk);
    frame_tick = 1'b0; frame_rst = 1'b0;
  endtask

  task automatic pix(input string name, input coord_t x, input coord_t y,
                     input int ea, input int eon, input int eidx);
    @(negedge Clk);
    DrawX = x; DrawY = y;
    @(negedge Clk);
    chk({name, " addr"}, 32'(read_address), ea);
    @(negedge Clk);
    @(negedge Clk);
    chk({name, " on"}, 32'(pixel_on), eon);
    chk({name, " idx"}, 32'(pixel_idx), eidx);
    $display("pix %s x=%0d y=%0d addr=%0d on=%0d idx=%0d", name, x, y,
             read_address, pixel_on, pixel_idx);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 5'd0;
    mem[0] = 5'd2;  mem[5] = 5'd1;    mem[45] = 5'd3;  mem[189] = 5'd4;
    mem[399] = 5'd7; mem[445] = 5'd5; mem[1199] = 5'd6;

    vecs[0] = '{x: 10'd105, y: 10'd52, addr: 45,  on: 1, idx: 3};
    vecs[1] = '{x: 10'd106, y: 10'd52, addr: 46,  on: 0, idx: 0};
    vecs[2] = '{x: 10'd120, y: 10'd52, addr: 0,   on: 0, idx: 0};
    vecs[3] = '{x: 10'd99,  y: 10'd52, addr: 0,   on: 0, idx: 0};
    vecs[4] = '{x: 10'd119, y: 10'd69, addr: 399, on: 1, idx: 7};
    vecs[5] = '{x: 10'd100, y: 10'd50, addr: 0,   on: 1, idx: 2};
    vecs[6] = '{x: 10'd105, y: 10'd70, addr: 0,   on: 0, idx: 0};
    vecs[7] = '{x: 10'd105, y: 10'd49, addr: 0,   on: 0, idx: 0};
    vecs[8] = '{x: 10'd0,   y: 10'd0,  addr: 0,   on: 0, idx: 0};

    // Reset state, then exact 3-cycle refill with latched position 0.
    DrawX = 10'd5; DrawY = 10'd0;
    repeat (3) @(negedge Clk);
    chk("rst addr", 32'(read_address), 0);
    chk("rst on", 32'(pixel_on), 0);
    chk("rst idx", 32'(pixel_idx), 0);
    chk("rst frame", 32'(cur_frame), 0);
    Reset_n = 1'b1;
    @(negedge Clk); chk("refill addr", 32'(read_address), 5);
    @(negedge Clk); chk("refill on@2", 32'(pixel_on), 0);
    @(negedge Clk); chk("refill on@3", 32'(pixel_on), 1);
    chk("refill idx@3", 32'(pixel_idx), 1);
    $display("reset sequence done");

    tick(10'd100, 10'd50, 1'b0);
    for (int i = 0; i < 9; i++)
      pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].addr, vecs[i].on, vecs[i].idx);

    // Position changes between ticks must not take effect.
    pos_x = 10'd300;
    pix("tear_hold", 10'd105, 10'd52, 45, 1, 3);
    tick(10'd300, 10'd50, 1'b0);
    pix("tear_new", 10'd305, 10'd52, 45, 1, 3);
    pix("tear_old", 10'd105, 10'd52, 0, 0, 0);

    tick(10'd630, 10'd470, 1'b0);
    pix("edge_in", 10'd639, 10'd479, 189, 1, 4);
    pix("edge_neg", 10'd0, 10'd479, 0, 0, 0);
    pix("edge_left", 10'd629, 10'd470, 0, 0, 0);

    // Animation sequencing.
    anim_en = 1'b1;
    repeat (7) tick(10'd100, 10'd50, 1'b0);
    chk("anim t7", 32'(cur_frame), 0);
    tick(10'd100, 10'd50, 1'b0);
    chk("anim t8", 32'(cur_frame), 1);
    $display("anim tick8 frame=%0d", cur_frame);
    pix("frame1", 10'd105, 10'd52, 445, 1, 5);
    repeat (8) tick(10'd100, 10'd50, 1'b0);
    chk("anim t16", 32'(cur_frame), 2);
    pix("frame2_last", 10'd119, 10'd69, 1199, 1, 6);
    repeat (8) tick(10'd100, 10'd50, 1'b0);
    chk("anim t24", 32'(cur_frame), 0);

    anim_en = 1'b0;
    repeat (10) tick(10'd100, 10'd50, 1'b0);
    chk("freeze", 32'(cur_frame), 0);
    anim_en = 1'b1;
    repeat (8) tick(10'd100, 10'd50, 1'b0);
    chk("resume t8", 32'(cur_frame), 1);
    repeat (7) tick(10'd100, 10'd50, 1'b0);
    chk("pre_rst", 32'(cur_frame), 1);
    tick(10'd100, 10'd50, 1'b1);
    chk("frame_rst", 32'(cur_frame), 0);
    repeat (7) tick(10'd100, 10'd50, 1'b0);
    chk("post_rst t7", 32'(cur_frame), 0);
    tick(10'd100, 10'd50, 1'b0);
    chk("post_rst t8", 32'(cur_frame), 1);
    $display("frame_rst sequence frame=%0d", cur_frame);

    // Asynchronous reset in the middle of an opaque run.
    pix("pre_reset", 10'd105, 10'd52, 445, 1, 5);
    #2 Reset_n = 1'b0;
    #1;
    chk("async on", 32'(pixel_on), 0);
    chk("async idx", 32'(pixel_idx), 0);
    chk("async addr", 32'(read_address), 0);
    chk("async frame", 32'(cur_frame), 0);
    DrawX = 10'd5; DrawY = 10'd0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk); @(negedge Clk);
    chk("midline on@2", 32'(pixel_on), 0);
    @(negedge Clk);
    chk("midline on@3", 32'(pixel_on), 1);
    chk("midline idx@3", 32'(pixel_idx), 1);
    $display("mid-line reset done");

`ifdef SPRITE_MIRROR_EN
    anim_en = 1'b0;
    mirror = 1'b1;
    tick(10'd100, 10'd50, 1'b0);
    pix("mirror_dx0", 10'd100, 10'd50, 19, 0, 0);
    pix("mirror_dx19", 10'd119, 10'd50, 0, 1, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Read-side engine for the per-sprite frame RAMs (20x20 duck/dog sprites; 3-bit palette index stored, 5-bit read data bus).
- Sits between the VGA controller's DrawX/DrawY and a sprite frameRAM instance.
- Generates read_address for the current pixel, tracks the RAM's 1-cycle read latency, and emits a pipeline-aligned palette index plus a pixel_on flag to the color mapper.
- Also sequences animation frames (e.g. flap 1/2/3, duckdown 1/2) and latches sprite position once per video frame to prevent tearing.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- NUM_FRAMES, 3, animation frames stored back-to-back in one RAM image (frame f at base f*SPR_W*SPR_H)
- ANIM_DIV, 8, video frames per animation step (>=1)
- TRANSPARENT_IDX, 0, palette index treated as background

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column from VGA controller
- DrawY  in  10  current pixel row from VGA controller
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- anim_en  in  1  1 = advance animation frames; 0 = hold current frame
- frame_rst  in  1  synchronous pulse forcing animation frame to 0
- read_address  out  19  to frameRAM read_address
- ram_data  in  5  from frameRAM data_Out
- pixel_idx  out  5  palette index for the color mapper
- pixel_on  out  1  sprite covers this pixel and is opaque
- cur_frame  out  2  current animation frame index

Behaviour:
- Reset (async assert, sync deassert by design intent):
  - read_address, pixel_idx, pixel_on, cur_frame = 0.
  - Latched position = 0. Tick divider = 0.
- Position latch:
  - On frame_tick, px_l <= pos_x and py_l <= pos_y.
  - The value present on pos_x/pos_y in the same cycle as frame_tick is the value captured.
  - Between ticks, pos_x/pos_y changes are ignored.
- Animation:
  - The divider counts frame_tick pulses while anim_en = 1.
  - When the divider reaches ANIM_DIV-1, it clears and cur_frame advances, wrapping NUM_FRAMES-1 -> 0.
  - anim_en = 0 freezes both the divider and cur_frame.
  - frame_rst has priority over an advance in the same cycle: cur_frame = 0 and divider = 0.
  - cur_frame updates only on frame_tick, so the frame index is stable for the whole active video frame.
- Pipeline, fixed latency 3 cycles from DrawX/DrawY to pixel_idx/pixel_on:
  - Stage 1 (cycle t+1):
    - Compute dx = DrawX - px_l and dy = DrawY - py_l as 11-bit signed values.
    - hit = (0 <= dx < SPR_W) and (0 <= dy < SPR_H).
    - Register read_address = cur_frame*SPR_W*SPR_H + dy*SPR_W + dx, zero-extended to 19 bits.
    - If hit = 0, read_address is still registered as cur_frame*SPR_W*SPR_H (in range, harmless).
    - Register hit_d1.
  - Stage 2 (cycle t+2): the RAM registers ram_data; the block registers hit_d2 <= hit_d1.
  - Stage 3 (cycle t+3):
    - pixel_on <= hit_d2 and (ram_data != TRANSPARENT_IDX).
    - pixel_idx <= ram_data when pixel_on, else 0.
- Boundaries:
  - Sprite partially off-screen: pos_x near 639, or any dx/dy negative → those pixels give pixel_on = 0; no address wrap.
  - Last sprite pixel: dx = SPR_W-1 and dy = SPR_H-1 gives address f*400+399.
  - Highest address: NUM_FRAMES*400-1.
  - Reset mid-line: outputs drop to 0 immediately; the pipeline refills in 3 cycles after deassert.
- Multiplies use constant SPR_W (shift-add acceptable). No multiplier on cur_frame: use a per-frame base lookup.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- When defined:
  - Adds input port mirror (1 bit), latched on frame_tick alongside position.
  - When the latched mirror is 1, the column term becomes (SPR_W-1-dx) (ducks flying left).
- When undefined: no port; column term is always dx.

Decomposition:
- Shared package sprite_pkg:
  - SPR_W/SPR_H defaults, SCREEN_W=640, SCREEN_H=480.
  - RAM_AW=19, PIX_W=5.
  - typedef pix_idx_t (logic [4:0]) and typedef coord_t (logic [9:0]).
  - Function frame_base(f) returning f*SPR_W*SPR_H.
- Natural sub-module sprite_anim_ctr:
  - Contains the frame_tick divider, cur_frame, and the position/mirror latch.
  - Instantiated inside sprite_fetch.

Test Plan:
- Reset: hold Reset_n = 0 with DrawX = 5 → read_address = 0, pixel_on = 0, cur_frame = 0. Deassert → first valid pixel_on exactly 3 cycles after the first in-window DrawX.
- Latch: pos_x = 100, pos_y = 50 with a frame_tick. Then DrawX = 105, DrawY = 52 → read_address = 45 one cycle later. RAM word 45 = 3 → pixel_on = 1, pixel_idx = 3 at t+3.
- Transparency/window: RAM word = 0 inside the window → pixel_on = 0. DrawX = 120 (dx = 20) → pixel_on = 0 regardless of RAM.
- Animation: ANIM_DIV = 8, anim_en = 1, 24 frame_ticks → cur_frame sequence 0→1→2→0 at ticks 8/16/24. read_address base becomes 400 in frame 1. frame_rst coincident with tick 16 → cur_frame = 0.
- No tearing: change pos_x mid-frame to 300 → addresses still use 100 until the next frame_tick.
- With SPRITE_MIRROR_EN: mirror = 1, dx = 0, dy = 0 → read_address = 19. dx = 19 → read_address = 0.
